// File: rtl/async_fifo_rd_drain.sv
// Read-side drain engine for async_fifo_top, clocked in the read domain.
// It pops words from the FIFO read port while the 3-entry output buffer has
// room for them. The buffer absorbs the 1-cycle FIFO read latency, so the
// valid/ready stream can run at one word per cycle.
// Optional build macro ASYNC_FIFO_SEQ_CHECK_EN adds a sticky check that each
// delivered word is the previous delivered word + 1. It is for the
// incrementing-pattern self-test. Without the macro, seq_err is tied low.
module async_fifo_rd_drain #(
  parameter int DWIDTH = 8,
  parameter int CNTW   = 16
) (
  input  logic              rclk,
  input  logic              reset,
  input  logic              en,
  input  logic              empty,
  output logic              pop,
  input  logic [DWIDTH-1:0] rdata,
  output logic              m_valid,
  output logic [DWIDTH-1:0] m_data,
  input  logic              m_ready,
  output logic              busy,
  output logic [CNTW-1:0]   word_cnt,
  output logic              seq_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t            state;
  logic [1:0]        occ;
  logic [1:0]        rd_ptr;
  logic [1:0]        wr_ptr;
  logic              inflight;
  logic [DWIDTH-1:0] q0;
  logic [DWIDTH-1:0] q1;
  logic [DWIDTH-1:0] q2;
  logic [2:0]        fill;
  logic              xfer;

  // Circular pointer over the three buffer slots.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // A pop is legal only if every word already owed to the buffer still fits.
  assign fill    = {1'b0, occ} + {2'b00, inflight};
  assign pop     = (state == RUN) && !empty && (fill < 3'd3);
  assign m_valid = (occ != 2'd0);
  assign xfer    = m_valid && m_ready;
  assign busy    = (state != IDLE);

  // The head-of-buffer slot drives the output word.
  always_comb begin
    case (rd_ptr)
      2'd0:    m_data = q0;
      2'd1:    m_data = q1;
      default: m_data = q2;
    endcase
  end

  // Drain control: RUN issues pops. STOP only drains words already owed.
  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (en) state <= RUN;
        RUN:  if (!en) state <= STOP;
        STOP: begin
          if (en)
            state <= RUN;
          else if ((occ == 2'd0) && !inflight)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output buffer. It captures rdata one cycle after each pop and releases
  // the head word on every transfer.
  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      q0       <= '0;
      q1       <= '0;
      q2       <= '0;
      rd_ptr   <= 2'd0;
      wr_ptr   <= 2'd0;
      occ      <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= pop;
      if (inflight) begin
        case (wr_ptr)
          2'd0:    q0 <= rdata;
          2'd1:    q1 <= rdata;
          default: q2 <= rdata;
        endcase
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (xfer)
        rd_ptr <= ptr_inc(rd_ptr);
      case ({inflight, xfer})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Delivered-word counter. It wraps naturally, and only reset clears it.
  always_ff @(posedge rclk or posedge reset) begin
    if (reset)
      word_cnt <= '0;
    else if (xfer)
      word_cnt <= word_cnt + CNTW'(1);
  end

`ifdef ASYNC_FIFO_SEQ_CHECK_EN
  logic [DWIDTH-1:0] prev_word;
  logic              seeded;

  // Sequence checker. The first word after reset seeds the reference.
  // Any later break in the +1 pattern latches seq_err.
  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      prev_word <= '0;
      seeded    <= 1'b0;
      seq_err   <= 1'b0;
    end else if (xfer) begin
      if (seeded && (m_data != prev_word + DWIDTH'(1)))
        seq_err <= 1'b1;
      prev_word <= m_data;
      seeded    <= 1'b1;
    end
  end
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_async_fifo_rd_drain.sv
// Directed bench for async_fifo_rd_drain. It uses a small FIFO read-port
// model that returns a programmable pattern one cycle after each pop.
module tb_async_fifo_rd_drain;

  logic       rclk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       empty = 1'b1;
  logic       pop;
  logic [7:0] rdata = 8'h00;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready = 1'b0;
  logic       busy;
  logic [3:0] word_cnt;
  logic       seq_err;

`ifdef ASYNC_FIFO_SEQ_CHECK_EN
  localparam logic SEQ_EXP = 1'b1;
`else
  localparam logic SEQ_EXP = 1'b0;
`endif

  async_fifo_rd_drain #(.DWIDTH(8), .CNTW(4)) dut (
    .rclk(rclk), .reset(reset), .en(en), .empty(empty), .pop(pop),
    .rdata(rdata), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .busy(busy), .word_cnt(word_cnt), .seq_err(seq_err)
  );

  always #5 rclk = ~rclk;

  // FIFO read-port model. Word k after the programmed base is base_val + k.
  // In skip mode, value base+2 is left out of the sequence.
  int         pop_idx = 0;
  int         base_idx = 0;
  logic [7:0] base_val = 8'h00;
  logic       skip = 1'b0;
  always @(posedge rclk) begin
    if (pop) begin
      rdata   <= base_val + 8'(pop_idx - base_idx)
                 + ((skip && (pop_idx - base_idx) >= 2) ? 8'd1 : 8'd0);
      pop_idx <= pop_idx + 1;
    end
  end

  typedef struct {
    logic       en;
    logic       empty;
    logic       rdy;
    logic       pop;
    logic       vld;
    logic       busy;
    logic [7:0] data;
  } vec_t;

  vec_t       tab [20];
  int         vecs = 0;
  int         fails = 0;
  logic [7:0] exp_next = 8'h00;
  int         deliv = 0;
  int         npop = 0;
  int         n = 0;
  int         was = 0;
  logic [7:0] seq_exp [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    @(negedge rclk);
  endtask

  // Check an in-order transfer, if one occurs this cycle, then advance.
  task automatic step();
    if (m_valid && m_ready) begin
      chk("stream_data", 32'(m_data), 32'(exp_next));
      exp_next = exp_next + 8'd1;
      deliv++;
    end
    tick();
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      en = tab[i].en; empty = tab[i].empty; m_ready = tab[i].rdy;
      #1;
      chk("tab_pop", 32'(pop), 32'(tab[i].pop));
      chk("tab_valid", 32'(m_valid), 32'(tab[i].vld));
      chk("tab_busy", 32'(busy), 32'(tab[i].busy));
      if (tab[i].vld)
        chk("tab_data", 32'(m_data), 32'(tab[i].data));
      tick();
    end
  endtask

  task automatic do_reset(input logic [7:0] base, input logic skp);
    reset = 1'b1; en = 1'b0; empty = 1'b1; m_ready = 1'b0;
    tick();
    tick();
    base_idx = pop_idx; base_val = base; skip = skp;
    reset = 1'b0;
  endtask

  function automatic vec_t mk(input logic e, input logic em, input logic r,
                              input logic p, input logic v, input logic b,
                              input logic [7:0] d);
    vec_t t;
    t.en = e; t.empty = em; t.rdy = r; t.pop = p; t.vld = v; t.busy = b; t.data = d;
    return t;
  endfunction

  initial begin
    // Rows 0..5: startup streaming. Rows 6..19: empty gap, then first word.
    tab[0] = mk(1, 0, 1, 0, 0, 0, 8'h00);
    tab[1] = mk(1, 0, 1, 1, 0, 1, 8'h00);
    tab[2] = mk(1, 0, 1, 1, 0, 1, 8'h00);
    tab[3] = mk(1, 0, 1, 1, 1, 1, 8'h00);
    tab[4] = mk(1, 0, 1, 1, 1, 1, 8'h01);
    tab[5] = mk(1, 0, 1, 1, 1, 1, 8'h02);
    tab[6] = mk(1, 1, 1, 0, 0, 0, 8'h00);
    for (int i = 7; i <= 15; i++) tab[i] = mk(1, 1, 1, 0, 0, 1, 8'h00);
    tab[16] = mk(1, 0, 1, 1, 0, 1, 8'h00);
    tab[17] = mk(1, 0, 1, 1, 0, 1, 8'h00);
    tab[18] = mk(1, 0, 1, 1, 1, 1, 8'h20);
    tab[19] = mk(1, 0, 1, 1, 1, 1, 8'h21);
    seq_exp[0] = 8'h00; seq_exp[1] = 8'h01; seq_exp[2] = 8'h03; seq_exp[3] = 8'h04;

    // Reset state
    tick();
    tick();
    chk("rst_pop", 32'(pop), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(word_cnt), 32'd0);
    chk("rst_seq", 32'(seq_err), 32'd0);

    // Full-rate streaming and counter wrap
    do_reset(8'h00, 1'b0);
    run_table(0, 5);
    exp_next = 8'h03;
    for (int i = 0; i < 14; i++) begin
      chk("stream_pop", 32'(pop), 32'd1);
      chk("stream_valid", 32'(m_valid), 32'd1);
      step();
    end
    chk("cnt_wrap", 32'(word_cnt), 32'd1);
    chk("seq_clean", 32'(seq_err), 32'd0);

    // Backpressure: the buffer fills, the output freezes, then drains in order
    m_ready = 1'b0;
    npop = 0;
    for (int i = 0; i < 8; i++) begin
      if (pop) npop++;
      chk("stall_valid", 32'(m_valid), 32'd1);
      chk("stall_data", 32'(m_data), 32'h11);
      tick();
    end
    chk("stall_pops_le3", 32'(npop <= 3), 32'd1);
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("resume_nogap", 32'(m_valid), 32'd1);
      step();
    end

    // Empty for 10 cycles, then the first word arrives two cycles after empty falls
    do_reset(8'h20, 1'b0);
    run_table(6, 19);
    exp_next = 8'h22;

    // Stop with occ=2 and inflight=1: exactly three words drain, then IDLE
    m_ready = 1'b0;
    tick();
    en = 1'b0;
    tick();
    m_ready = 1'b1;
    deliv = 0;
    for (int i = 0; i < 8; i++) begin
      chk("stop_pop", 32'(pop), 32'd0);
      step();
    end
    chk("stop_deliv", 32'(deliv), 32'd3);
    chk("stop_idle", 32'(busy), 32'd0);
    en = 1'b1;
    for (int i = 0; i < 4 && !pop; i++) tick();
    chk("restart_pop", 32'(pop), 32'd1);
    deliv = 0;
    for (int i = 0; i < 6; i++) step();
    chk("restart_deliv", 32'(deliv >= 3), 32'd1);

    // Asynchronous reset with occ=2; no stale word survives
    m_ready = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("arst_pop", 32'(pop), 32'd0);
    chk("arst_valid", 32'(m_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    base_idx = pop_idx; base_val = 8'h40; skip = 1'b0;
    reset = 1'b0; en = 1'b1; empty = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 8 && !m_valid; i++) tick();
    chk("arst_first_valid", 32'(m_valid), 32'd1);
    chk("arst_first_data", 32'(m_data), 32'h40);
    tick();
    exp_next = 8'h41;
    for (int i = 0; i < 3; i++) step();

    // Sequence check with pattern 00,01,03,04
    do_reset(8'h00, 1'b1);
    en = 1'b1; empty = 1'b0; m_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (m_valid) begin
        chk("seq_data", 32'(m_data), 32'(seq_exp[n]));
        was = n;
        n++;
        tick();
        if (was == 1) chk("seq_before_gap", 32'(seq_err), 32'd0);
        if (was == 2) chk("seq_on_gap", 32'(seq_err), 32'(SEQ_EXP));
        if (n == 4) break;
      end else begin
        tick();
      end
    end
    chk("seq_words", 32'(n), 32'd4);
    empty = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("seq_sticky", 32'(seq_err), 32'(SEQ_EXP));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/async_fifo_rd_drain.md
Name: async_fifo_rd_drain

Overview:
Read-side drain engine for async_fifo_top, clocked in the read domain. Pops words from the FIFO read port (pop/rdata/empty) whenever downstream credit exists. Delivers them on a valid/ready stream with no loss or duplication. A 3-entry output buffer absorbs the FIFO's 1-cycle read latency so full throughput is sustained. It is the consumer counterpart of the write-side push driver.

Parameters:
DWIDTH, 8, data width of rdata and m_data
CNTW, 16, width of delivered-word counter word_cnt

Ports:
rclk  input  1  read-domain clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
en  input  1  drain enable, sampled on rclk
empty  input  1  FIFO empty flag, synchronous to rclk
pop  output  1  FIFO pop request (combinational)
rdata  input  DWIDTH  FIFO read data, valid the cycle after a pop
m_valid  output  1  output word valid
m_data  output  DWIDTH  output word
m_ready  input  1  downstream accept
busy  output  1  high when FSM not in IDLE
word_cnt  output  CNTW  count of words delivered (m_valid && m_ready)
seq_err  output  1  sticky sequence error (see Optional Feature)

Behaviour:
- Interface: one clock (rclk); reset is asynchronous and active-high (reset).
- Reset values: pop 0, m_valid 0, m_data 0, busy 0, word_cnt 0, seq_err 0. FSM goes to IDLE; buffer, occ and inflight are cleared.
- Reset mid-operation: buffered and in-flight words are discarded. The rdata arriving for a pre-reset pop is ignored.
- FSM states:
  - IDLE: en=1 -> RUN.
  - RUN: en=0 -> STOP.
  - STOP: en=1 -> RUN; else occ==0 && inflight==0 -> IDLE.
- busy = (state != IDLE).
- FIFO read timing: pop sampled high at the end of cycle t. rdata is valid during cycle t+1 and is captured at the end of t+1. inflight is a 1-bit register, inflight <= pop.
- Pop rule: pop = (state==RUN) && !empty && (occ + inflight < 3). occ is the buffer occupancy, 0..3.
- The buffer never overflows. With m_ready held high, pop can assert every cycle.
- Latency: empty falls in cycle t -> pop in t -> m_valid in t+2.
- Output stream:
  - Buffer is FIFO-ordered. m_valid = (occ != 0); m_data = head entry.
  - m_data and m_valid stay stable while m_valid && !m_ready.
  - On the same edge, capture and transfer together leave occ unchanged, and ordering is preserved.
- In STOP, no new pops are issued. Buffered and in-flight words are still delivered.
- word_cnt increments by 1 on each transfer and wraps modulo 2^CNTW. Only reset clears it.
- en toggling has no effect on data already captured or in flight.

Optional Feature:
Macro ASYNC_FIFO_SEQ_CHECK_EN.
- Defined: each delivered word is compared to the previously delivered word + 1 modulo 2^DWIDTH. The first word after reset only seeds the reference. On mismatch, seq_err goes to 1 on the transfer edge and stays 1 until reset. This matches the incrementing-pattern self-test bench.
- Undefined: no check logic is built; seq_err is tied to 0.

Test Plan:
1. Reset, then en=1, empty=0 constant, FIFO model returns 00,01,02,..., m_ready=1 -> pop high every cycle from the first RUN cycle. m_data is 00,01,02,... one word per cycle. With CNTW=4, word_cnt reads 1 after 17 transfers.
2. Streaming, then m_ready=0 -> pop asserts at most 3 more times then stays low. m_valid=1 with m_data frozen. Raise m_ready -> remaining words follow in order with no gap, loss or duplicate.
3. empty=1 for 10 cycles with en=1 -> pop=0 and m_valid=0 throughout. Drop empty in cycle t -> pop=1 in t and m_valid=1 in t+2 with the correct word.
4. With occ=2 and inflight=1, drive en=0 -> pop=0 from the cycle after en is sampled low. Exactly 3 further words are delivered. busy falls the cycle after the last transfer. Reassert en -> popping resumes.
5. Assert reset mid-stream with occ=2 -> pop, m_valid and busy go low immediately, without waiting for a clock edge. After release with en=1 and a new pattern starting at 0x40, the first m_data is 0x40, with no stale words.
6. Macro defined, FIFO returns 00,01,03,04 -> seq_err=1 after the transfer of 03 and stays 1. Macro undefined with the same stimulus -> seq_err stays 0.
